// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: FSM state codes, default widths
// and the {load_n, shift_right} control words driven to the downstream shifter.
package shift_sequencer_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] GAP   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    typedef struct packed {
        logic load_n;
        logic shift_right;
    } ctrl_t;

    localparam ctrl_t CTRL_HOLD  = '{load_n: 1'b1, shift_right: 1'b0};
    localparam ctrl_t CTRL_LOAD  = '{load_n: 1'b0, shift_right: 1'b0};
    localparam ctrl_t CTRL_SHIFT = '{load_n: 1'b1, shift_right: 1'b1};

    // Only LOAD and SHIFT produce an active control word; the two are exclusive.
    function automatic ctrl_t ctrl_for(input logic [2:0] st);
        ctrl_t c;
        c = CTRL_HOLD;
        if (st == LOAD)
            c = CTRL_LOAD;
        else if (st == SHIFT)
            c = CTRL_SHIFT;
        return c;
    endfunction

endpackage

// File: rtl/shift_sequencer_pacer.sv
// Down-counter that times the hold gap between paced shift pulses.
// start reloads it; expired is high in the last of PACE_CYCLES gap cycles.
module shift_sequencer_pacer #(
    parameter int PACE_CYCLES = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    output logic expired
);

    localparam int PW = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
    localparam logic [PW-1:0] RELOAD = PW'((PACE_CYCLES > 0) ? PACE_CYCLES - 1 : 0);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (start)
            cnt <= RELOAD;
        else if (cnt != '0)
            cnt <= cnt - PW'(1);
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Job sequencer for the 8-bit load/shift register: LOAD, N shift pulses, DONE.
// Define SHIFT_SEQUENCER_PACE_EN to insert PACE_CYCLES hold cycles between shifts.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int PACE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [CNT_W-1:0] req_count,
    input  logic             req_arith,
    input  logic             abort,
    output logic [WIDTH-1:0] load_val,
    output logic             load_n,
    output logic             shift_right,
    output logic             asr,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

`ifdef SHIFT_SEQUENCER_PACE_EN
    localparam bit PACED = 1'b1;
`else
    localparam bit PACED = 1'b0;
`endif
    localparam bit GAP_EN = PACED && (PACE_CYCLES > 0);

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             arith_q;
    logic             accept;
    logic             abort_take;
    logic             pace_expired;
    ctrl_t            ctrl_nxt;

    // A job is taken only when req_ready is already high, so the first IDLE
    // cycle after reset (req_ready still low) never accepts.
    assign accept     = (state == IDLE) && req_valid && req_ready;
    assign abort_take = abort && ((state == LOAD) || (state == SHIFT) || (state == GAP));

`ifdef SHIFT_SEQUENCER_PACE_EN
    logic pace_start;
    assign pace_start = (state == SHIFT) && (state_nxt == GAP);

    shift_sequencer_pacer #(
        .PACE_CYCLES (PACE_CYCLES)
    ) u_pacer (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (pace_start),
        .expired (pace_expired)
    );
`else
    assign pace_expired = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = LOAD;
                    cnt_nxt   = req_count;
                end
            end
            LOAD: begin
                if (abort_take)
                    state_nxt = IDLE;
                else if (cnt == '0)
                    state_nxt = DONE;
                else
                    state_nxt = SHIFT;
            end
            SHIFT: begin
                // cnt holds the pulses still owed, including this cycle's.
                if (abort_take) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state_nxt = DONE;
                    else if (GAP_EN)
                        state_nxt = GAP;
                    else
                        state_nxt = SHIFT;
                end
            end
            GAP: begin
                if (abort_take)
                    state_nxt = IDLE;
                else if (pace_expired)
                    state_nxt = SHIFT;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ctrl_nxt = ctrl_for(state_nxt);

    // Outputs are registered from the next state so each one lines up with
    // the cycle its state occupies.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            arith_q     <= 1'b0;
            req_ready   <= 1'b0;
            load_val    <= '0;
            load_n      <= 1'b1;
            shift_right <= 1'b0;
            asr         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                arith_q  <= req_arith;
                load_val <= req_data;
            end
            req_ready   <= (state_nxt == IDLE);
            busy        <= (state_nxt != IDLE);
            done        <= (state_nxt == DONE);
            aborted     <= abort_take;
            load_n      <= ctrl_nxt.load_n;
            shift_right <= ctrl_nxt.shift_right;
            asr         <= (state_nxt == IDLE) ? 1'b0 : (accept ? req_arith : arith_q);
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: reset, normal, zero-count, ASR, abort,
// long-count and mid-job reset jobs, checked cycle by cycle on the falling edge.
module tb_shift_sequencer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
`ifdef SHIFT_SEQUENCER_PACE_EN
    localparam int PACE = 3;
`else
    localparam int PACE = 0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [WIDTH-1:0] req_data = '0;
    logic [CNT_W-1:0] req_count = '0;
    logic             req_arith = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] load_val;
    logic             load_n;
    logic             shift_right;
    logic             asr;
    logic             busy;
    logic             done;
    logic             aborted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_sequencer #(
        .WIDTH       (WIDTH),
        .CNT_W       (CNT_W),
        .PACE_CYCLES (3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .req_count   (req_count),
        .req_arith   (req_arith),
        .abort       (abort),
        .load_val    (load_val),
        .load_n      (load_n),
        .shift_right (shift_right),
        .asr         (asr),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    // Vector layout: {req_ready, load_val, load_n, shift_right, asr, busy, done, aborted}
    task automatic check_out(input string tag, input logic r, input logic [7:0] lv,
                             input logic ln, input logic sr, input logic a,
                             input logic b, input logic d, input logic ab);
        logic [14:0] obs;
        logic [14:0] exp;
        obs = {req_ready, load_val, load_n, shift_right, asr, busy, done, aborted};
        exp = {r, lv, ln, sr, a, b, d, ab};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge in an IDLE cycle with req_ready high; returns at
    // the falling edge of the IDLE cycle that follows the job.
    task automatic run_job(input string tag, input logic [7:0] d, input logic [3:0] n,
                           input logic a, input int abort_at, input bit abort_in_done);
        req_valid = 1'b1;
        req_data  = d;
        req_count = n;
        req_arith = a;
        @(negedge clk);
        req_valid = 1'b0;
        req_data  = ~d;
        req_count = 4'd0;
        req_arith = ~a;
        check_out({tag, " load"}, 1'b0, d, 1'b0, 1'b0, a, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= int'(n); k++) begin
`ifdef SHIFT_SEQUENCER_PACE_EN
            if (k > 1) begin
                for (int g = 0; g < PACE; g++) begin
                    @(negedge clk);
                    check_out({tag, " gap"}, 1'b0, d, 1'b1, 1'b0, a, 1'b1, 1'b0, 1'b0);
                end
            end
`endif
            @(negedge clk);
            check_out({tag, " shift"}, 1'b0, d, 1'b1, 1'b1, a, 1'b1, 1'b0, 1'b0);
            if (k == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check_out({tag, " aborted"}, 1'b1, d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                return;
            end
        end
        @(negedge clk);
        check_out({tag, " done"}, 1'b0, d, 1'b1, 1'b0, a, 1'b1, 1'b1, 1'b0);
        if (abort_in_done)
            abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_out({tag, " idle"}, 1'b1, d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held low for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_out("reset", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        reset_n = 1'b1;
        #1;
        check_out("release pre-edge", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_out("first ready", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_job("b4 n3", 8'hB4, 4'd3, 1'b0, 0, 1'b0);
        run_job("n0", 8'h5A, 4'd0, 1'b0, 0, 1'b1);

        // abort while idle has no effect
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_out("idle abort", 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_job("asr 81", 8'h81, 4'd2, 1'b1, 0, 1'b0);
        run_job("abort n5", 8'h3C, 4'd5, 1'b0, 2, 1'b0);
        run_job("long n10", 8'hFF, 4'd10, 1'b1, 0, 1'b0);

        // reset asserted mid-job (inside the gap when pacing is built in)
        req_valid = 1'b1;
        req_data  = 8'h77;
        req_count = 4'd4;
        req_arith = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check_out("midrst load", 1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check_out("midrst shift1", 1'b0, 8'h77, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
`ifdef SHIFT_SEQUENCER_PACE_EN
        check_out("midrst gap", 1'b0, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
`else
        check_out("midrst shift2", 1'b0, 8'h77, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
        reset_n = 1'b0;
        #1;
        check_out("midrst async", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_out("midrst held", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        check_out("midrst ready", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_job("post n1", 8'h0F, 4'd1, 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Upstream control stage for the 8-bit load/shift register on the lab board. It accepts one shift job per handshake: a data byte, a shift count and an arithmetic flag. It then drives the register's load value, active-low load, shift-right and ASR controls cycle by cycle, and reports completion or abort. It replaces manual KEY pressing with a deterministic sequence on the shared clock.

## Interface
Parameters:
- WIDTH, 8, data width; matches the downstream shift register.
- CNT_W, 4, shift-count width; counts 0..2^CNT_W-1 are legal.
- PACE_CYCLES, 3, hold cycles inserted between shift pulses; used only when pacing is compiled in.

Ports:
- clk  in  1  single clock, shared with the downstream shift register.
- reset_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  job request.
- req_ready  out  1  block is idle and will accept a job.
- req_data  in  WIDTH  value to load.
- req_count  in  CNT_W  number of right shifts.
- req_arith  in  1  1 = arithmetic shift (ASR); 0 = logical shift.
- abort  in  1  cancel the job in progress.
- load_val  out  WIDTH  parallel load value to the shifter.
- load_n  out  1  active-low load strobe.
- shift_right  out  1  shift enable.
- asr  out  1  arithmetic-shift select.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse: job completed.
- aborted  out  1  one-cycle pulse: job cancelled.

## Operation
- All outputs are registered. Reset values while reset_n is low:
  - req_ready=0, load_val=0, load_n=1, shift_right=0, asr=0, busy=0, done=0, aborted=0.
  - State is IDLE.
- States:
  - IDLE: req_ready=1. On req_valid & req_ready, latch data, count and arith, then go to LOAD.
  - LOAD: one cycle with load_n=0 and load_val=data.
    - Go to SHIFT if count>0, otherwise go to DONE.
  - SHIFT: shift_right=1 for exactly one cycle per remaining count; the count decrements each cycle.
    - Go to DONE after the last shift.
    - With pacing compiled in, go to GAP between shifts.
  - GAP (paced builds only): hold for PACE_CYCLES cycles with shift_right=0 and load_n=1, then return to SHIFT.
  - DONE: done=1 for one cycle, then go to IDLE.
- busy=1 in LOAD, SHIFT, GAP and DONE.
- asr=arith from LOAD through DONE; asr=0 in IDLE. load_val holds the latched data until the next job.
- Hold condition, used in every other cycle: load_n=1 and shift_right=0.
- load_n=0 and shift_right=1 never occur together.
- Counts greater than WIDTH are legal; the sequencer still issues every pulse.
- abort sampled high in LOAD, SHIFT or GAP:
  - Next cycle: the IDLE outputs are restored, aborted=1 for one cycle, and done stays 0.
  - abort in IDLE or DONE is ignored.
- Asserting reset_n low mid-job returns the block to the reset values immediately, with no done and no aborted pulse.

## Timing
- Handshake completes at edge T. LOAD occupies cycle T+1.
- Shifts occupy cycles T+2 .. T+1+N. done is high in cycle T+2+N, and req_ready returns in cycle T+3+N.
- N=0: done is high in cycle T+2.
- Paced builds: shift k (k from 1) occurs at cycle T+1+k+(k-1)·PACE_CYCLES.
- req_ready is low from T+1 until the job finishes. A req_valid held high starts the next job in the first IDLE cycle.
- First req_ready=1 appears one clk edge after reset_n deasserts.

## Configuration
- SHIFT_SEQUENCER_PACE_EN defined: GAP state and pace counter are present, and PACE_CYCLES applies.
- SHIFT_SEQUENCER_PACE_EN undefined: shifts are back-to-back, GAP is unreachable or absent, and PACE_CYCLES is ignored.

## Structure
- Package shift_sequencer_pkg contains:
  - State encoding: IDLE, LOAD, SHIFT, GAP, DONE.
  - Default WIDTH and CNT_W constants.
  - Control-word constants for hold, load and shift.
- Sub-module shift_sequencer_pacer: a PACE_CYCLES down-counter with start/expired signals. It is instantiated only under SHIFT_SEQUENCER_PACE_EN.

## Test plan
- Reset: hold reset_n low for 3 cycles.
  - Response: all outputs at their reset values. req_ready=1 one cycle after release.
- Job with data 0xB4, count 3, arith 0, unpaced:
  - Cycle T+1: load_n=0, load_val=0xB4.
  - Cycles T+2..T+4: shift_right=1.
  - Cycle T+5: done=1. Cycle T+6: req_ready=1.
- Job with count 0:
  - Cycle T+1: load strobe. Cycle T+2: done.
  - shift_right is never 1.
- Job with data 0x81, count 2, arith 1:
  - asr=1 in cycles T+1..T+4 and 0 afterwards.
  - Two shift pulses are issued.
- Job with count 5; abort pulsed after the 2nd shift:
  - Next cycle: shift_right=0 and aborted=1.
  - done is never 1. Exactly 2 shift pulses are issued.
- Paced build with PACE_CYCLES=3, count 2:
  - Shifts at cycles T+2 and T+6. done at cycle T+7.
  - A reset pulse mid-GAP returns all outputs to their reset values immediately.
